// File: rtl/avalon_packet_arbiter_pkg.sv
// avalon_arb_pack
// Shared types and constants for the two-input Avalon-ST packet arbiter.
//   arb_state_t      : arbiter FSM states
//   PKT_COUNT_WIDTH  : width of the optional per-input packet counters
//   GRANT_*          : one-hot owner encodings used on the grant bus
//   sat_inc          : saturating increment for the packet counters
package avalon_arb_pack;

  typedef enum logic [1:0] {IDLE, GRANT_FIRST, GRANT_SECOND} arb_state_t;

  localparam int PKT_COUNT_WIDTH = 16;

  localparam logic [1:0] GRANT_NONE      = 2'b00;
  localparam logic [1:0] GRANT_FIRST_OH  = 2'b01;
  localparam logic [1:0] GRANT_SECOND_OH = 2'b10;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [PKT_COUNT_WIDTH-1:0] sat_inc(input logic [PKT_COUNT_WIDTH-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/avalon_packet_arbiter_rr_picker.sv
// avalon_rr_picker
// Two-requester round-robin picker. Produces a one-hot winner from the
// request bits and remembers who was granted last.
//   clk, rst   : clock, asynchronous active-high reset
//   req[1:0]   : request bits, bit 0 = first requester, bit 1 = second
//   update_en  : commit the current winner as the new last grant
//   winner[1:0]: one-hot winner, 2'b00 when nobody requests
module avalon_rr_picker
  import avalon_arb_pack::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] winner
);

  logic [1:0] last_grant_q;
  logic [1:0] last_grant_d;

  // On a tie the requester that did not win last time gets the output.
  always_comb begin
    winner = GRANT_NONE;
    unique case (req)
      2'b01:   winner = GRANT_FIRST_OH;
      2'b10:   winner = GRANT_SECOND_OH;
      2'b11:   winner = (last_grant_q == GRANT_FIRST_OH) ? GRANT_SECOND_OH : GRANT_FIRST_OH;
      default: winner = GRANT_NONE;
    endcase
    last_grant_d = update_en ? winner : last_grant_q;
  end

  // Resetting to "second" lets the first requester win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GRANT_SECOND_OH;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/avalon_packet_arbiter.sv
// avalon_packet_arbiter
// Packet-level round-robin arbiter merging two Avalon-ST streams into one
// without interleaving packets. A winner owns msg_out from SOP through EOP.
// Non-SOP beats that show up while idle are drained and flagged.
//   clk, rst            : clock, asynchronous active-high reset
//   first_msg_in_*      : requester 0 stream (data/valid/ready/sop/eop/empty)
//   second_msg_in_*     : requester 1 stream
//   msg_out_*           : merged output stream
//   first_drop_indi     : one-cycle pulse, a stray requester 0 beat was dropped
//   second_drop_indi    : same for requester 1
//   grant[1:0]          : one-hot owner of msg_out, 2'b00 while idle
// Optional feature macro AVALON_ARB_PKT_COUNT_EN adds first_pkt_count and
// second_pkt_count, saturating counts of forwarded EOP beats per input.
module avalon_packet_arbiter
  import avalon_arb_pack::*;
#(
  parameter  int DATA_WIDTH_IN_BYTES = 16,
  localparam int DATA_W  = DATA_WIDTH_IN_BYTES * 8,
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1
)
(
  input  logic               clk,
  input  logic               rst,

  input  logic [DATA_W-1:0]  first_msg_in_data,
  input  logic               first_msg_in_valid,
  output logic               first_msg_in_ready,
  input  logic               first_msg_in_sop,
  input  logic               first_msg_in_eop,
  input  logic [EMPTY_W-1:0] first_msg_in_empty,

  input  logic [DATA_W-1:0]  second_msg_in_data,
  input  logic               second_msg_in_valid,
  output logic               second_msg_in_ready,
  input  logic               second_msg_in_sop,
  input  logic               second_msg_in_eop,
  input  logic [EMPTY_W-1:0] second_msg_in_empty,

  output logic [DATA_W-1:0]  msg_out_data,
  output logic               msg_out_valid,
  input  logic               msg_out_ready,
  output logic               msg_out_sop,
  output logic               msg_out_eop,
  output logic [EMPTY_W-1:0] msg_out_empty,

  output logic               first_drop_indi,
  output logic               second_drop_indi,
  output logic [1:0]         grant
`ifdef AVALON_ARB_PKT_COUNT_EN
  ,
  output logic [PKT_COUNT_WIDTH-1:0] first_pkt_count,
  output logic [PKT_COUNT_WIDTH-1:0] second_pkt_count
`endif
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       first_drop_q, first_drop_d;
  logic       second_drop_q, second_drop_d;

  logic [1:0] req;
  logic [1:0] winner;
  logic       pick_update;

  assign req = {second_msg_in_valid & second_msg_in_sop,
                first_msg_in_valid  & first_msg_in_sop};

  avalon_rr_picker u_picker (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .update_en (pick_update),
    .winner    (winner)
  );

  // Drain readiness is gated by rst so no stray beat is consumed while the
  // drop flags are held in reset and could not report it.
  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    first_drop_d        = 1'b0;
    second_drop_d       = 1'b0;
    pick_update         = 1'b0;
    msg_out_data        = '0;
    msg_out_valid       = 1'b0;
    msg_out_sop         = 1'b0;
    msg_out_eop         = 1'b0;
    msg_out_empty       = '0;
    first_msg_in_ready  = 1'b0;
    second_msg_in_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        first_msg_in_ready  = first_msg_in_valid  & ~first_msg_in_sop  & ~rst;
        second_msg_in_ready = second_msg_in_valid & ~second_msg_in_sop & ~rst;
        first_drop_d        = first_msg_in_ready;
        second_drop_d       = second_msg_in_ready;
        if (winner == GRANT_FIRST_OH) begin
          state_d     = GRANT_FIRST;
          grant_d     = GRANT_FIRST_OH;
          pick_update = 1'b1;
        end else if (winner == GRANT_SECOND_OH) begin
          state_d     = GRANT_SECOND;
          grant_d     = GRANT_SECOND_OH;
          pick_update = 1'b1;
        end
      end

      GRANT_FIRST: begin
        msg_out_data       = first_msg_in_data;
        msg_out_valid      = first_msg_in_valid;
        msg_out_sop        = first_msg_in_sop;
        msg_out_eop        = first_msg_in_eop;
        msg_out_empty      = first_msg_in_empty;
        first_msg_in_ready = msg_out_ready;
        if (first_msg_in_valid && msg_out_ready && first_msg_in_eop) begin
          state_d = IDLE;
          grant_d = GRANT_NONE;
        end
      end

      GRANT_SECOND: begin
        msg_out_data        = second_msg_in_data;
        msg_out_valid       = second_msg_in_valid;
        msg_out_sop         = second_msg_in_sop;
        msg_out_eop         = second_msg_in_eop;
        msg_out_empty       = second_msg_in_empty;
        second_msg_in_ready = msg_out_ready;
        if (second_msg_in_valid && msg_out_ready && second_msg_in_eop) begin
          state_d = IDLE;
          grant_d = GRANT_NONE;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= GRANT_NONE;
      first_drop_q  <= 1'b0;
      second_drop_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      first_drop_q  <= first_drop_d;
      second_drop_q <= second_drop_d;
    end
  end

  assign grant            = grant_q;
  assign first_drop_indi  = first_drop_q;
  assign second_drop_indi = second_drop_q;

`ifdef AVALON_ARB_PKT_COUNT_EN
  logic [PKT_COUNT_WIDTH-1:0] first_pkt_count_q, first_pkt_count_d;
  logic [PKT_COUNT_WIDTH-1:0] second_pkt_count_q, second_pkt_count_d;

  // A packet counts when its EOP beat actually transfers to msg_out.
  always_comb begin
    first_pkt_count_d  = first_pkt_count_q;
    second_pkt_count_d = second_pkt_count_q;
    if (state_q == GRANT_FIRST && first_msg_in_valid && msg_out_ready && first_msg_in_eop) begin
      first_pkt_count_d = sat_inc(first_pkt_count_q);
    end
    if (state_q == GRANT_SECOND && second_msg_in_valid && msg_out_ready && second_msg_in_eop) begin
      second_pkt_count_d = sat_inc(second_pkt_count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_pkt_count_q  <= '0;
      second_pkt_count_q <= '0;
    end else begin
      first_pkt_count_q  <= first_pkt_count_d;
      second_pkt_count_q <= second_pkt_count_d;
    end
  end

  assign first_pkt_count  = first_pkt_count_q;
  assign second_pkt_count = second_pkt_count_q;
`endif

endmodule

// File: tb/tb_avalon_packet_arbiter.sv
// Testbench for avalon_packet_arbiter. Source queues feed both inputs one
// beat per cycle with a ready handshake; expected output beats (tagged with
// the grant that should own them) are queued in arbitration order and
// popped whenever msg_out transfers a beat.
module tb_avalon_packet_arbiter;

  localparam int DW_BYTES = 16;
  localparam int DATA_W   = DW_BYTES * 8;
  localparam int EMPTY_W  = 4;

  typedef struct packed {
    logic [1:0]         grant;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } beat_t;

  logic               clk;
  logic               rst;
  logic [DATA_W-1:0]  first_msg_in_data;
  logic               first_msg_in_valid;
  logic               first_msg_in_ready;
  logic               first_msg_in_sop;
  logic               first_msg_in_eop;
  logic [EMPTY_W-1:0] first_msg_in_empty;
  logic [DATA_W-1:0]  second_msg_in_data;
  logic               second_msg_in_valid;
  logic               second_msg_in_ready;
  logic               second_msg_in_sop;
  logic               second_msg_in_eop;
  logic [EMPTY_W-1:0] second_msg_in_empty;
  logic [DATA_W-1:0]  msg_out_data;
  logic               msg_out_valid;
  logic               msg_out_ready;
  logic               msg_out_sop;
  logic               msg_out_eop;
  logic [EMPTY_W-1:0] msg_out_empty;
  logic               first_drop_indi;
  logic               second_drop_indi;
  logic [1:0]         grant;
`ifdef AVALON_ARB_PKT_COUNT_EN
  logic [15:0]        first_pkt_count;
  logic [15:0]        second_pkt_count;
`endif

  avalon_packet_arbiter #(.DATA_WIDTH_IN_BYTES(DW_BYTES)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .first_msg_in_data   (first_msg_in_data),
    .first_msg_in_valid  (first_msg_in_valid),
    .first_msg_in_ready  (first_msg_in_ready),
    .first_msg_in_sop    (first_msg_in_sop),
    .first_msg_in_eop    (first_msg_in_eop),
    .first_msg_in_empty  (first_msg_in_empty),
    .second_msg_in_data  (second_msg_in_data),
    .second_msg_in_valid (second_msg_in_valid),
    .second_msg_in_ready (second_msg_in_ready),
    .second_msg_in_sop   (second_msg_in_sop),
    .second_msg_in_eop   (second_msg_in_eop),
    .second_msg_in_empty (second_msg_in_empty),
    .msg_out_data        (msg_out_data),
    .msg_out_valid       (msg_out_valid),
    .msg_out_ready       (msg_out_ready),
    .msg_out_sop         (msg_out_sop),
    .msg_out_eop         (msg_out_eop),
    .msg_out_empty       (msg_out_empty),
    .first_drop_indi     (first_drop_indi),
    .second_drop_indi    (second_drop_indi),
    .grant               (grant)
`ifdef AVALON_ARB_PKT_COUNT_EN
    ,
    .first_pkt_count     (first_pkt_count),
    .second_pkt_count    (second_pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t src0_q[$];
  beat_t src1_q[$];
  beat_t exp_q[$];

  int compared   = 0;
  int mismatched = 0;

  logic [1:0]        s_grant;
  logic              s_ready0, s_ready1, s_valid, s_drop0, s_drop1;
  logic [DATA_W-1:0] s_data;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Queues a packet of len beats on one source; every byte of beat i is base+i.
  task automatic queuePacket(input int src, input int len, input logic [7:0] base, input bit expect_out);
    beat_t b;
    logic [7:0] byte_val;
    for (int i = 0; i < len; i++) begin
      byte_val = base + 8'(i);
      b.grant  = (src == 0) ? 2'b01 : 2'b10;
      b.sop    = (i == 0);
      b.eop    = (i == len - 1);
      b.empty  = (i == len - 1) ? 4'd3 : 4'd0;
      b.data   = {DW_BYTES{byte_val}};
      if (src == 0) src0_q.push_back(b);
      else          src1_q.push_back(b);
      if (expect_out) exp_q.push_back(b);
    end
  endtask

  task automatic presentHeads();
    if (src0_q.size() > 0) begin
      first_msg_in_valid = 1'b1;
      first_msg_in_data  = src0_q[0].data;
      first_msg_in_sop   = src0_q[0].sop;
      first_msg_in_eop   = src0_q[0].eop;
      first_msg_in_empty = src0_q[0].empty;
    end else begin
      first_msg_in_valid = 1'b0;
      first_msg_in_data  = '0;
      first_msg_in_sop   = 1'b0;
      first_msg_in_eop   = 1'b0;
      first_msg_in_empty = '0;
    end
    if (src1_q.size() > 0) begin
      second_msg_in_valid = 1'b1;
      second_msg_in_data  = src1_q[0].data;
      second_msg_in_sop   = src1_q[0].sop;
      second_msg_in_eop   = src1_q[0].eop;
      second_msg_in_empty = src1_q[0].empty;
    end else begin
      second_msg_in_valid = 1'b0;
      second_msg_in_data  = '0;
      second_msg_in_sop   = 1'b0;
      second_msg_in_eop   = 1'b0;
      second_msg_in_empty = '0;
    end
  endtask

  // One clock: present queue heads, sample at negedge, score any output
  // transfer, then retire source beats that were accepted.
  task automatic applyStimulus();
    beat_t act;
    bit acc0, acc1;
    presentHeads();
    @(negedge clk);
    s_grant  = grant;
    s_ready0 = first_msg_in_ready;
    s_ready1 = second_msg_in_ready;
    s_valid  = msg_out_valid;
    s_data   = msg_out_data;
    s_drop0  = first_drop_indi;
    s_drop1  = second_drop_indi;
    if (msg_out_valid && msg_out_ready) begin
      act.grant = grant;
      act.sop   = msg_out_sop;
      act.eop   = msg_out_eop;
      act.empty = msg_out_empty;
      act.data  = msg_out_data;
      checkOutput("out_beat_expected", 256'(exp_q.size() > 0), 256'd1);
      if (exp_q.size() > 0) checkOutput("out_beat", 256'(act), 256'(exp_q.pop_front()));
    end
    acc0 = first_msg_in_valid && first_msg_in_ready;
    acc1 = second_msg_in_valid && second_msg_in_ready;
    @(posedge clk);
    #1;
    if (acc0) void'(src0_q.pop_front());
    if (acc1) void'(src1_q.pop_front());
  endtask

  task automatic runUntilDrained(input string tag, input int budget);
    int n = 0;
    while ((src0_q.size() + src1_q.size() + exp_q.size()) > 0 && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_drained"}, 256'(src0_q.size() + src1_q.size() + exp_q.size()), 256'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    presentHeads();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    rst           = 1'b1;
    msg_out_ready = 1'b1;
    presentHeads();

    // Reset values
    #12;
    checkOutput("rst_grant",       256'(grant), 256'd0);
    checkOutput("rst_drop0",       256'(first_drop_indi), 256'd0);
    checkOutput("rst_drop1",       256'(second_drop_indi), 256'd0);
    checkOutput("rst_out_valid",   256'(msg_out_valid), 256'd0);
    checkOutput("rst_out_sop_eop", 256'({msg_out_sop, msg_out_eop}), 256'd0);
    checkOutput("rst_out_data",    256'(msg_out_data), 256'd0);
    checkOutput("rst_out_empty",   256'(msg_out_empty), 256'd0);
    checkOutput("rst_readies",     256'({first_msg_in_ready, second_msg_in_ready}), 256'd0);
`ifdef AVALON_ARB_PKT_COUNT_EN
    checkOutput("rst_counts", 256'({first_pkt_count, second_pkt_count}), 256'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single request, 4-beat packet of 8'd34 bytes
    $display("[TB] single request");
    queuePacket(0, 4, 8'd34, 1'b1);
    for (int i = 0; i < 4; i++) src0_q[i].data = {DW_BYTES{8'd34}};
    for (int i = 0; i < 4; i++) exp_q[i].data  = {DW_BYTES{8'd34}};
    applyStimulus();
    checkOutput("t1_idle_grant", 256'(s_grant), 256'd0);
    checkOutput("t1_idle_ready", 256'(s_ready0), 256'd0);
    checkOutput("t1_idle_valid", 256'(s_valid), 256'd0);
    applyStimulus();
    checkOutput("t1_grant_first", 256'(s_grant), 256'd1);
    checkOutput("t1_sop_valid",   256'(s_valid), 256'd1);
    repeat (3) applyStimulus();
    applyStimulus();
    checkOutput("t1_gap_grant", 256'(s_grant), 256'd0);
    checkOutput("t1_gap_valid", 256'(s_valid), 256'd0);
    checkOutput("t1_all_beats", 256'(exp_q.size()), 256'd0);

    // Tie, round-robin: expected order first, second, first, second
    $display("[TB] tie round-robin");
    doReset();
    queuePacket(0, 3, 8'h10, 1'b1);
    queuePacket(1, 3, 8'h20, 1'b1);
    queuePacket(0, 3, 8'h30, 1'b1);
    queuePacket(1, 3, 8'h40, 1'b1);
    runUntilDrained("t2", 60);

    // Stray non-SOP beat on second input while idle
    $display("[TB] stray beat");
    applyStimulus();
    begin
      beat_t stray;
      stray.grant = 2'b10;
      stray.sop   = 1'b0;
      stray.eop   = 1'b0;
      stray.empty = '0;
      stray.data  = {DW_BYTES{8'hAA}};
      src1_q.push_back(stray);
    end
    applyStimulus();
    checkOutput("t3_stray_ready", 256'(s_ready1), 256'd1);
    checkOutput("t3_stray_valid", 256'(s_valid), 256'd0);
    checkOutput("t3_drop_early",  256'(s_drop1), 256'd0);
    checkOutput("t3_consumed",    256'(src1_q.size()), 256'd0);
    applyStimulus();
    checkOutput("t3_drop_pulse",  256'(s_drop1), 256'd1);
    checkOutput("t3_drop0_quiet", 256'(s_drop0), 256'd0);
    applyStimulus();
    checkOutput("t3_drop_end",    256'(s_drop1), 256'd0);

    // Backpressure mid-packet with second input waiting
    $display("[TB] backpressure");
    queuePacket(0, 4, 8'h50, 1'b1);
    repeat (3) applyStimulus();
    queuePacket(1, 1, 8'h60, 1'b1);
    msg_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("t4_ready0_low", 256'(s_ready0), 256'd0);
      checkOutput("t4_data_held",  256'(s_data), 256'({DW_BYTES{8'h52}}));
      checkOutput("t4_ready1_low", 256'(s_ready1), 256'd0);
      checkOutput("t4_no_drop1",   256'(s_drop1), 256'd0);
      checkOutput("t4_grant",      256'(s_grant), 256'd1);
    end
    msg_out_ready = 1'b1;
    runUntilDrained("t4", 30);

    // Reset after beat 2 of 4
    $display("[TB] reset mid-packet");
    applyStimulus();
    queuePacket(0, 4, 8'h70, 1'b1);
    repeat (3) applyStimulus();
    checkOutput("t5_two_beats_out", 256'(exp_q.size()), 256'd2);
    presentHeads();
    #1;
    checkOutput("t5_pre_valid", 256'(msg_out_valid), 256'd1);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid",   256'(msg_out_valid), 256'd0);
    checkOutput("t5_rst_grant",   256'(grant), 256'd0);
    checkOutput("t5_rst_readies", 256'({first_msg_in_ready, second_msg_in_ready}), 256'd0);
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    presentHeads();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    queuePacket(1, 2, 8'h80, 1'b1);
    runUntilDrained("t5", 20);

`ifdef AVALON_ARB_PKT_COUNT_EN
    // Packet counters: tie order first, second, first, second, first
    $display("[TB] packet counters");
    doReset();
    queuePacket(0, 1, 8'h90, 1'b1);
    queuePacket(1, 1, 8'hA0, 1'b1);
    queuePacket(0, 2, 8'hB0, 1'b1);
    queuePacket(1, 2, 8'hC0, 1'b1);
    queuePacket(0, 2, 8'hD0, 1'b1);
    runUntilDrained("t6", 60);
    applyStimulus();
    checkOutput("t6_first_count",  256'(first_pkt_count), 256'd3);
    checkOutput("t6_second_count", 256'(second_pkt_count), 256'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/avalon_packet_arbiter.md
# avalon_packet_arbiter

Packet-level round-robin arbiter that merges two Avalon-ST message streams into one output stream without interleaving packets. It sits in front of `avalon_enforcer`. Once an input wins, it owns the output from its SOP beat through its EOP beat. Stray non-SOP beats that arrive while no packet is in flight are drained and flagged.

## Interface
- `DATA_WIDTH_IN_BYTES`, default 16. Byte width of `data` on all three interfaces.
- `clk`  in  1. Single clock for the whole block.
- `rst`  in  1. Asynchronous, active-high reset.
- `first_msg_in`  `avalon_st_if.slave`  `DATA_WIDTH_IN_BYTES`. Requester 0.
- `second_msg_in`  `avalon_st_if.slave`  `DATA_WIDTH_IN_BYTES`. Requester 1.
- `msg_out`  `avalon_st_if.master`  `DATA_WIDTH_IN_BYTES`. Merged output stream.
- `first_drop_indi`  out  1. One-cycle pulse: one non-SOP beat of requester 0 was discarded.
- `second_drop_indi`  out  1. Same, for requester 1.
- `grant`  out  2. One-hot owner of `msg_out`. `2'b00` while IDLE.

## Operation
- The FSM has three states: IDLE, GRANT_FIRST and GRANT_SECOND.
- **IDLE:**
  - A "request" is `valid && sop` on an input.
  - With exactly one request, move to that input's GRANT state.
  - With both requesting, grant the input that was not granted last (the `last_grant` register), then update `last_grant`.
  - No data is forwarded in IDLE. `msg_out.valid` is 0.
  - An input showing `valid && !sop` gets `ready = 1` and its beat is dropped. That input's `*_drop_indi` pulses.
  - An input showing `valid && sop` gets `ready = 0` while IDLE.
- **GRANT_x:**
  - `msg_out` `data`, `valid`, `sop`, `eop` and `empty` are driven combinationally from input x.
  - Input x `ready` equals `msg_out.ready`.
  - The other input's `ready` is 0, and it is never dropped while a packet is in flight.
- **Leaving GRANT_x:** on a beat with `valid && ready && eop`, go to IDLE. A single-beat packet (SOP and EOP together) therefore takes one forwarding cycle.
- **SOP mid-packet:** a repeated SOP, or a missing EOP, on the granted input is forwarded unchanged. The state stays GRANT_x until EOP. Enforcing packet structure is `avalon_enforcer`'s job.
- **Grant update:** `last_grant` updates only when a GRANT state is entered, not on packet completion.

## Timing
- **Reset values:**
  - State IDLE, `last_grant` = second (so requester 0 wins the first tie).
  - `grant = 0`, both `*_drop_indi = 0`.
  - `msg_out.valid/sop/eop = 0`, `data/empty = 0`, both input `ready = 0`.
- Reset asserted mid-packet forces IDLE immediately (asynchronously), drops `msg_out.valid`, and leaves the partial packet unterminated.
- **Grant latency:** one clock. A request seen at edge n enters GRANT at edge n+1. The SOP beat can transfer in cycle n+1 if `msg_out.ready` is high.
- **Datapath latency:** zero cycles while in GRANT, since the datapath is combinational.
- **Inter-packet gap:** exactly one IDLE cycle between packets.
- **Drop indication:** `*_drop_indi` is registered. It is high for the one cycle after the dropped beat's edge.
- **Backpressure:** with `msg_out.ready = 0` during GRANT, input x sees `ready = 0`. The input must hold its beat, and state is unchanged.
- `grant` is registered and valid for the whole GRANT state.

## Configuration
- **`AVALON_ARB_PKT_COUNT_EN` defined:**
  - Adds outputs `first_pkt_count` and `second_pkt_count` (16 bits each).
  - Each counter increments on every forwarded EOP beat of its input and saturates at 16'hFFFF.
  - Reset value is 0.
- **`AVALON_ARB_PKT_COUNT_EN` undefined:** the ports and counters do not exist. All other behaviour is identical.

## Structure
- Package `avalon_arb_pack` holds:
  - `typedef enum logic [1:0] {IDLE, GRANT_FIRST, GRANT_SECOND} arb_state_t`.
  - `localparam int PKT_COUNT_WIDTH = 16`.
  - Constants `GRANT_NONE`, `GRANT_FIRST_OH` and `GRANT_SECOND_OH`.
- One sub-module, `avalon_rr_picker`:
  - Inputs: the two request bits and `last_grant`.
  - Output: a one-hot winner.
  - It holds the `last_grant` flop and its update enable.
- The top level holds the FSM, the output mux, the drain logic and the optional counters.

## Test plan
1. **Single request:** from reset, only `first_msg_in` sends a 4-beat packet (`data = {16{8'd34}}`), `msg_out.ready = 1`.
   - `grant = 2'b01` one cycle after SOP is presented.
   - All 4 beats appear on `msg_out` unchanged.
   - IDLE for 1 cycle after EOP.
2. **Tie, round-robin:** both inputs present SOP simultaneously, each with a 3-beat packet, repeated twice.
   - Grant order is first, second, first, second.
   - No interleaving of beats.
3. **Stray beat:** `second_msg_in` presents `valid = 1`, `sop = 0` in IDLE.
   - `second_msg_in.ready = 1`, and the beat is not seen on `msg_out`.
   - `second_drop_indi` is high for exactly one cycle, one cycle later.
4. **Backpressure:** `msg_out.ready = 0` for 5 cycles in the middle of a granted packet.
   - Granted input `ready = 0` during those cycles, and `data` is held.
   - The other input's SOP waits, with `ready = 0` and no drop.
5. **Reset mid-packet:** assert `rst` after beat 2 of 4.
   - `msg_out.valid`, `grant` and the readies go to 0 immediately.
   - After release, a new SOP is granted normally.
6. **Counters (with `AVALON_ARB_PKT_COUNT_EN`):** 3 first packets and 2 second packets, one of each single-beat.
   - `first_pkt_count = 3` and `second_pkt_count = 2`.
